// File: rtl/div_pkg.sv
// Shared encodings for the sequential RISC-V divider: funct3[1:0] operation codes
// and the controller state type.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and record the quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN+1:0] shifted;
  logic            take;

  always_comb begin
    shifted = {rem_i, quot_i[XLEN-1]};
    take    = (shifted >= {2'b00, divisor_i});
    rem_o   = take ? (shifted[XLEN:0] - {1'b0, divisor_i}) : shifted[XLEN:0];
    quot_o  = {quot_i[XLEN-2:0], take};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with RISC-V divide-by-zero
// and overflow results, a req/busy/ready handshake and a pipeline flush.
module div_seq
  import div_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o
);

  localparam int ITERS = XLEN / STEPS_PER_CYCLE;
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  if (!((XLEN == 32) || (XLEN == 64)) ||
      !((STEPS_PER_CYCLE == 1) || (STEPS_PER_CYCLE == 2) || (STEPS_PER_CYCLE == 4)) ||
      ((XLEN % STEPS_PER_CYCLE) != 0)) begin : g_bad_param
    $error("div_seq: unsupported XLEN/STEPS_PER_CYCLE combination");
  end

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sign_quot_q, sign_quot_d;
  logic            sign_rem_q, sign_rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] result_q, result_d;

  // Quotient register doubles as the dividend shift register: its MSB feeds the
  // remainder each step while the new quotient bit enters at the LSB.
  logic [XLEN:0]   rem_chain  [STEPS_PER_CYCLE+1];
  logic [XLEN-1:0] quot_chain [STEPS_PER_CYCLE+1];

  assign rem_chain[0]  = rem_q;
  assign quot_chain[0] = quot_q;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_chain[i]),
      .quot_i    (quot_chain[i]),
      .divisor_i (divisor_q),
      .rem_o     (rem_chain[i+1]),
      .quot_o    (quot_chain[i+1])
    );
  end

  logic            in_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] quot_fin, rem_fin;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    op_d        = op_q;
    sign_quot_d = sign_quot_q;
    sign_rem_d  = sign_rem_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    ready_d     = 1'b0;
    result_d    = result_q;

    in_signed = op_is_signed(op_i);
    a_mag     = (in_signed && a_i[XLEN-1]) ? -a_i : a_i;
    b_mag     = (in_signed && b_i[XLEN-1]) ? -b_i : b_i;
    quot_fin  = sign_quot_q ? -quot_chain[STEPS_PER_CYCLE] : quot_chain[STEPS_PER_CYCLE];
    rem_fin   = sign_rem_q ? -rem_chain[STEPS_PER_CYCLE][XLEN-1:0]
                           : rem_chain[STEPS_PER_CYCLE][XLEN-1:0];

    if (flush_i) begin
      state_d = DIV_ST_IDLE;
    end else begin
      case (state_q)
        DIV_ST_IDLE, DIV_ST_DONE: begin
          state_d = DIV_ST_IDLE;
          if (req_i) begin
            op_d        = op_i;
            sign_quot_d = in_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            sign_rem_d  = in_signed && a_i[XLEN-1];
            quot_d      = a_mag;
            rem_d       = '0;
            divisor_d   = b_mag;
            cnt_d       = CNT_W'(ITERS);
            if (b_i == '0) begin
              state_d  = DIV_ST_DONE;
              ready_d  = 1'b1;
              result_d = op_is_rem(op_i) ? a_i : '1;
            end else if (in_signed && (a_i == MOST_NEG) && (b_i == '1)) begin
              state_d  = DIV_ST_DONE;
              ready_d  = 1'b1;
              result_d = op_is_rem(op_i) ? '0 : a_i;
            end else begin
              state_d = DIV_ST_CALC;
              busy_d  = 1'b1;
            end
          end
        end
        DIV_ST_CALC: begin
          rem_d  = rem_chain[STEPS_PER_CYCLE];
          quot_d = quot_chain[STEPS_PER_CYCLE];
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DIV_ST_DONE;
            ready_d  = 1'b1;
            result_d = op_is_rem(op_q) ? rem_fin : quot_fin;
          end else begin
            busy_d = 1'b1;
          end
        end
        default: state_d = DIV_ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= DIV_ST_IDLE;
      op_q        <= '0;
      sign_quot_q <= 1'b0;
      sign_rem_q  <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sign_quot_q <= sign_quot_d;
      sign_rem_q  <= sign_rem_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      result_q    <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed RISC-V corner cases, flush, back-to-back
// and asynchronous reset, plus random operations against an arithmetic model.
module tb_div_seq;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, flush = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, ready;
  logic [31:0] result;

  logic        req4 = 1'b0, flush4 = 1'b0;
  logic [1:0]  op4 = '0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        busy4, ready4;
  logic [31:0] result4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_seq #(.XLEN(32), .STEPS_PER_CYCLE(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .busy_o(busy), .ready_o(ready), .result_o(result)
  );

  div_seq #(.XLEN(32), .STEPS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .op_i(op4), .a_i(a4), .b_i(b4),
    .flush_i(flush4), .busy_o(busy4), .ready_o(ready4), .result_o(result4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_ovf(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return !o[0] && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension results from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (is_ovf(o, x, y)) return o[1] ? 32'h0 : x;
    case (o)
      DIV_OP_DIV:  return 32'(sx / sy);
      DIV_OP_DIVU: return x / y;
      DIV_OP_REM:  return 32'(sx % sy);
      default:     return x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input int iters);
    return ((y == 0) || is_ovf(o, x, y)) ? 1 : iters + 1;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that raised ready.
  task automatic run_op(input bit use4, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] res);
    if (use4) begin req4 = 1'b1; op4 = o; a4 = x; b4 = y; end
    else      begin req  = 1'b1; op  = o; a  = x; b  = y; end
    @(posedge clk); #1;
    req = 1'b0; req4 = 1'b0;
    lat = 1;
    while (!(use4 ? ready4 : ready) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(use4 ? ready4 : ready)) check("ready_timeout", use4 ? ready4 : ready, 1);
    check("busy_at_ready", use4 ? busy4 : busy, 0);
    res = use4 ? result4 : result;
  endtask

  task automatic directed(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] res;
    run_op(1'b0, o, x, y, lat, res);
    check({tag, "_res"}, res, exp);
    check({tag, "_model"}, res, model(o, x, y));
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat2, seen;
    logic [31:0] res, prev, x, y;
    logic [1:0]  o;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_result", result, 0);
    check("rst_result4", result4, 0);
    rst = 1'b0;

    directed("div_m7_2",   DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    directed("rem_m7_2",   DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    directed("divu_big_3", DIV_OP_DIVU, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 33);
    directed("remu_big_3", DIV_OP_REMU, 32'h8000_0000, 32'd3,         32'h0000_0002, 33);
    directed("divu_by0",   DIV_OP_DIVU, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1);
    directed("rem_by0",    DIV_OP_REM,  32'h0000_1234, 32'd0,         32'h0000_1234, 1);
    directed("div_ovf",    DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf",    DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    directed("div_7_m2",   DIV_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    directed("rem_7_m2",   DIV_OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33);

    // Flush during CALC: no ready pulse, result retained.
    prev = result;
    req = 1'b1; op = DIV_OP_DIVU; a = 32'hFFFF_FFFF; b = 32'd3;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", busy, 0);
    check("flush_ready_after", ready, 0);
    check("flush_result_kept", result, prev);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) seen = 1;
    end
    check("flush_no_ready", seen, 0);
    directed("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Back-to-back: req held through busy (ignored) and through DONE (accepted).
    req = 1'b1; op = DIV_OP_DIV; a = 32'hFFFF_FF9C; b = 32'd7;
    @(posedge clk); #1;
    op = DIV_OP_REMU; a = 32'd1000; b = 32'd33;
    lat = 1;
    while (!ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat1", lat, 33);
    check("b2b_res1", result, model(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7));
    @(posedge clk); #1;
    req = 1'b0;
    check("b2b_busy2", busy, 1);
    lat2 = 1;
    while (!ready && lat2 < 200) begin
      @(posedge clk); #1;
      lat2++;
    end
    check("b2b_lat2", lat2, 33);
    check("b2b_res2", result, model(DIV_OP_REMU, 32'd1000, 32'd33));

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        default: y = 32'($urandom);
      endcase
      run_op(1'b0, o, x, y, lat, res);
      check($sformatf("rand%0d_res op=%0d a=%h b=%h", i, o, x, y), res, model(o, x, y));
      check($sformatf("rand%0d_lat", i), lat, model_lat(o, x, y, 32));
    end

    // Four steps per cycle.
    run_op(1'b1, DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res);
    check("s4_div_res", res, 32'hFFFF_FFFD);
    check("s4_div_lat", lat, 9);
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      x = 32'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      run_op(1'b1, o, x, y, lat, res);
      check($sformatf("s4_rand%0d_res", i), res, model(o, x, y));
      check($sformatf("s4_rand%0d_lat", i), lat, model_lat(o, x, y, 8));
    end

    // Asynchronous reset in the middle of CALC.
    run_op(1'b0, DIV_OP_DIVU, 32'd1000, 32'd7, lat, res);
    check("pre_rst_res", res, 32'd142);
    req = 1'b1; op = DIV_OP_DIVU; a = 32'hFFFF_FFFF; b = 32'd5;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", ready, 0);
    check("arst_result", result, 0);
    check("arst_result4", result4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    directed("post_rst_divu", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
